// File: rtl/seg_led_pkg.sv
// Shared constants and helpers for the seven-segment scan path.
// Build macro SEG_LED_LZB_EN (leading-zero blanking) is consumed by seg_led_scan.
package seg_led_pkg;

    localparam int SEG_NUM_DIG_DEF = 4;
    localparam int SEG_CLK_DIV_DEF = 50000;

    // Digit index width; never narrower than one bit.
    function automatic int dig_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Idle level of the digit-select pads for up to 8 digits.
    function automatic logic [7:0] sel_inactive(input bit act_low);
        return act_low ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Free-running prescaler: tick_o is high for one cycle every CLK_DIV cycles.
// Combinational tick from the registered count; no backpressure.
module seg_scan_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_led_scan.sv
// Digit scanner for a multiplexed seven-segment display; outputs registered, updated one cycle after each tick.
// Optional leading-zero blanking under macro SEG_LED_LZB_EN; writes are double-buffered per frame.
module seg_led_scan
    import seg_led_pkg::*;
#(
    parameter int NUM_DIG     = SEG_NUM_DIG_DEF,
    parameter int CLK_DIV     = SEG_CLK_DIV_DEF,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [4*NUM_DIG-1:0]   wr_data,
    input  logic [NUM_DIG-1:0]     dig_en,
    output logic [3:0]             data_disp,
    output logic [NUM_DIG-1:0]     dig_sel,
    output logic                   frame_done
);

    localparam int                 IW       = dig_idx_w(NUM_DIG);
    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] SEL_OFF  = NUM_DIG'(sel_inactive(DIG_ACT_LOW != 0));

    logic                 tick;
    logic                 started_q, started_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*NUM_DIG-1:0] pending_q, pending_d;
    logic [4*NUM_DIG-1:0] shadow_q, shadow_d;
    logic [3:0]           disp_q, disp_d;
    logic [NUM_DIG-1:0]   sel_q, sel_d;
    logic                 fd_q, fd_d;
    logic                 boundary;
    logic                 dig_on;
    logic [NUM_DIG-1:0]   onehot;

`ifdef SEG_LED_LZB_EN
    // Digit i>0 is blanked when it and every more-significant nibble are zero.
    function automatic logic lz_blank(input logic [4*NUM_DIG-1:0] v, input logic [IW-1:0] i);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (k >= int'(i) && v[4*k +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        return (i != '0) && all_zero;
    endfunction
`endif

    seg_scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

    always_comb begin
        started_d = started_q;
        idx_d     = idx_q;
        pending_d = wr_en ? wr_data : pending_q;
        shadow_d  = shadow_q;
        boundary  = 1'b0;
        disp_d    = disp_q;
        sel_d     = sel_q;
        fd_d      = 1'b0;
        dig_on    = 1'b0;
        onehot    = '0;

        if (tick) begin
            // The very first tick only arms the scanner; digit 0 gets the first slot.
            boundary  = !started_q || (idx_q == LAST_IDX);
            started_d = 1'b1;
            if (started_q) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            end
            if (boundary) begin
                shadow_d = wr_en ? wr_data : pending_q;
            end
            fd_d = started_q && (idx_q == LAST_IDX);

            onehot = NUM_DIG'(1) << idx_d;
            dig_on = dig_en[idx_d] && started_d;
`ifdef SEG_LED_LZB_EN
            dig_on = dig_on && !lz_blank(shadow_d, idx_d);
`endif
            disp_d = shadow_d[4*idx_d +: 4];
            sel_d  = (dig_on ? onehot : '0) ^ SEL_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
            idx_q     <= '0;
            pending_q <= '0;
            shadow_q  <= '0;
            disp_q    <= 4'h0;
            sel_q     <= SEL_OFF;
            fd_q      <= 1'b0;
        end else begin
            started_q <= started_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            sel_q     <= sel_d;
            fd_q      <= fd_d;
        end
    end

    assign data_disp  = disp_q;
    assign dig_sel    = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_led_scan.sv
// Randomised bench for seg_led_scan against a slot/frame-level reference model.
// Honours SEG_LED_LZB_EN in the model when the macro is defined.
module tb_seg_led_scan;

    localparam int ND = 4;
    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic [3:0]  dig_en = 4'hF;
    logic [3:0]  data_disp;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Model: cycles since reset, ticks seen, last write, frame value, expected outputs.
    int          m_cyc;
    int          m_nt;
    logic [15:0] m_pend;
    logic [15:0] m_shadow;
    logic [3:0]  m_dd;
    logic [3:0]  m_sel;
    logic        m_fd;

    seg_led_scan #(
        .NUM_DIG     (ND),
        .CLK_DIV     (CD),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .dig_en     (dig_en),
        .data_disp  (data_disp),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc    = 0;
        m_nt     = 0;
        m_pend   = 16'h0;
        m_shadow = 16'h0;
        m_dd     = 4'h0;
        m_sel    = 4'hF;
        m_fd     = 1'b0;
    endtask

    function automatic int cur_dig();
        return (m_nt == 0) ? -1 : (m_nt - 1) % ND;
    endfunction

    function automatic bit next_is_frame_tick();
        return ((m_cyc % CD) == CD - 1) && ((m_nt % ND) == 0);
    endfunction

    // One clock: drive at negedge, advance model at posedge, compare just after.
    task automatic step(input logic we, input logic [15:0] wd, input logic [3:0] en);
        bit tick;
        int dig;
        bit act;
        @(negedge clk);
        wr_en   = we;
        wr_data = wd;
        dig_en  = en;
        @(posedge clk);
        tick = ((m_cyc % CD) == CD - 1);
        m_cyc++;
        m_fd = 1'b0;
        if (tick) begin
            m_nt++;
            dig = (m_nt - 1) % ND;
            if (dig == 0) begin
                m_shadow = we ? wd : m_pend;
                m_fd     = (m_nt > 1);
            end
            m_dd = 4'((m_shadow >> (4 * dig)) & 16'hF);
            act  = en[dig];
`ifdef SEG_LED_LZB_EN
            act = act && (dig == 0 || (m_shadow >> (4 * dig)) != 16'h0);
`endif
            m_sel = act ? ~(4'b0001 << dig) : 4'hF;
        end
        if (we) begin
            m_pend = wd;
        end
        #1;
        check("data_disp", {28'h0, data_disp}, {28'h0, m_dd});
        check("dig_sel", {28'h0, dig_sel}, {28'h0, m_sel});
        check("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
    endtask

    task automatic idle(input int n, input logic [3:0] en);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 16'h0, en);
        end
    endtask

    task automatic wait_digit(input int d);
        for (int k = 0; k < 64 && cur_dig() != d; k++) begin
            step(1'b0, 16'h0, 4'hF);
        end
        check("reach_digit", cur_dig(), d);
    endtask

    initial begin
        logic [15:0] wd;
        logic [3:0]  en;
        bit          we;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_disp", {28'h0, data_disp}, 32'h0);
        check("rst_dig_sel", {28'h0, dig_sel}, 32'hF);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        #2;
        rst = 1'b0;
        model_reset();

        // Basic scan of 1234, then a mid-frame write that must wait for the frame edge.
        step(1'b1, 16'h1234, 4'hF);
        idle(24, 4'hF);
        wait_digit(1);
        step(1'b1, 16'hABCD, 4'hF);
        idle(40, 4'hF);

        // Write landing on the frame-boundary tick goes straight to the frame.
        for (int k = 0; k < 64 && !next_is_frame_tick(); k++) begin
            step(1'b0, 16'h0, 4'hF);
        end
        check("frame_tick_sync", {31'h0, next_is_frame_tick()}, 32'h1);
        step(1'b1, 16'h5678, 4'hF);
        idle(20, 4'hF);

        step(1'b1, 16'hFFFF, 4'b1010);
        idle(40, 4'b1010);

        // Asynchronous reset in the digit-2 slot; old value must not return.
        wait_digit(2);
        #1 rst = 1'b1;
        #1;
        check("arst_data_disp", {28'h0, data_disp}, 32'h0);
        check("arst_dig_sel", {28'h0, dig_sel}, 32'hF);
        check("arst_frame_done", {31'h0, frame_done}, 32'h0);
        #1 rst = 1'b0;
        model_reset();
        idle(40, 4'hF);

        step(1'b1, 16'h0070, 4'hF);
        idle(36, 4'hF);
        step(1'b1, 16'h0000, 4'hF);
        idle(36, 4'hF);

        en = 4'hF;
        for (int k = 0; k < 900; k++) begin
            we = ($urandom_range(0, 7) == 0);
            wd = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            if ($urandom_range(0, 15) == 0) begin
                en = 4'($urandom);
            end
            step(we, wd, en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
